// File: rtl/fetch_prefetch_buffer.sv
// Instruction-fetch front end: sequential word fetcher feeding a small
// {pc, insn} FIFO that the IF stage drains with a valid/ready handshake.
// A redirect flushes the queue and restarts fetch at a new PC. Any response
// still in flight for the old stream is discarded through the FLUSH state.
module fetch_prefetch_buffer #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   // instruction memory side
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   // IF stage side
   output logic        fetch_valid,
   output logic [31:0] fetch_insn,
   output logic [31:0] fetch_pc,
   input  logic        fetch_ready,
   // control flow change
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   // IDLE : no request outstanding (queue full)
   // REQ  : request outstanding for the live instruction stream
   // FLUSH: request outstanding for a stream killed by a redirect
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_REQ   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [1:0]       state_reg,    state_next;
   logic             mem_req_reg,  mem_req_next;
   logic [31:0]      mem_addr_reg, mem_addr_next;
   logic [31:0]      next_pc_reg,  next_pc_next;
   logic [CNT_W-1:0] count_reg,    count_next;
   logic [PTR_W-1:0] rd_ptr_reg,   rd_ptr_next;
   logic [PTR_W-1:0] wr_ptr_reg,   wr_ptr_next;

   // Small queue kept in registers so the head is visible combinationally
   // in the same cycle the count becomes non-zero.
   logic [31:0] pc_mem   [DEPTH];
   logic [31:0] insn_mem [DEPTH];

   // ------------------------------------------------------------------
   // Datapath helpers
   // ------------------------------------------------------------------
   logic        ack_hit;
   logic        push;
   logic        pop;
   logic        room;
   logic [31:0] redirect_pc_aligned;
   logic [31:0] mem_addr_inc;

   // Push/pop qualification; a redirect cancels both in its cycle.
   always_comb begin
      ack_hit             = mem_req_reg && mem_ack;
      push                = ack_hit && (state_reg == ST_REQ) && !redirect;
      pop                 = (count_reg != '0) && fetch_ready && !redirect;
      redirect_pc_aligned = redirect_pc & 32'hFFFF_FFFC;
      mem_addr_inc        = mem_addr_reg + 32'd4;
   end

   // Occupancy and pointer update, including the redirect flush.
   always_comb begin
      count_next  = count_reg;
      rd_ptr_next = rd_ptr_reg;
      wr_ptr_next = wr_ptr_reg;
      if (redirect) begin
         count_next  = '0;
         rd_ptr_next = '0;
         wr_ptr_next = '0;
      end else begin
         if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
         endcase
      end
      // A new request is only issued if its response is guaranteed a slot.
      room = (count_next < CNT_FULL);
   end

   // Fetch FSM: request sequencing, address generation and flush handling.
   always_comb begin
      state_next    = state_reg;
      mem_req_next  = mem_req_reg;
      mem_addr_next = mem_addr_reg;
      next_pc_next  = next_pc_reg;

      if (redirect) begin
         next_pc_next = redirect_pc_aligned;
         case (state_reg)
            ST_IDLE: begin
               state_next    = ST_REQ;
               mem_req_next  = 1'b1;
               mem_addr_next = redirect_pc_aligned;
            end
            ST_REQ, ST_FLUSH: begin
               if (mem_ack) begin
                  // The outstanding request completes now, so the new
                  // stream can be requested straight away.
                  state_next    = ST_REQ;
                  mem_req_next  = 1'b1;
                  mem_addr_next = redirect_pc_aligned;
               end else begin
                  // Request must be held until acked; its data is stale.
                  state_next    = ST_FLUSH;
                  mem_req_next  = 1'b1;
               end
            end
            default: begin
               state_next    = ST_IDLE;
               mem_req_next  = 1'b0;
               mem_addr_next = next_pc_reg;
            end
         endcase
      end else begin
         case (state_reg)
            ST_IDLE: begin
               mem_addr_next = next_pc_reg;
               if (room) begin
                  state_next   = ST_REQ;
                  mem_req_next = 1'b1;
               end
            end
            ST_REQ: begin
               if (mem_ack) begin
                  next_pc_next  = mem_addr_inc;
                  mem_addr_next = mem_addr_inc;
                  if (!room) begin
                     state_next   = ST_IDLE;
                     mem_req_next = 1'b0;
                  end
               end
            end
            ST_FLUSH: begin
               if (mem_ack) begin
                  // Stale data dropped; count is zero here, so room exists.
                  state_next    = ST_REQ;
                  mem_req_next  = 1'b1;
                  mem_addr_next = next_pc_reg;
               end
            end
            default: begin
               state_next    = ST_IDLE;
               mem_req_next  = 1'b0;
               mem_addr_next = next_pc_reg;
            end
         endcase
      end
   end

   // Control state registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         mem_req_reg  <= 1'b0;
         mem_addr_reg <= RESET_PC;
         next_pc_reg  <= RESET_PC;
         count_reg    <= '0;
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
      end else begin
         state_reg    <= state_next;
         mem_req_reg  <= mem_req_next;
         mem_addr_reg <= mem_addr_next;
         next_pc_reg  <= next_pc_next;
         count_reg    <= count_next;
         rd_ptr_reg   <= rd_ptr_next;
         wr_ptr_reg   <= wr_ptr_next;
      end
   end

   // Queue storage write; contents need no reset because the outputs are
   // masked while the queue is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_reg]   <= mem_addr_reg;
         insn_mem[wr_ptr_reg] <= mem_rdata;
      end
   end

   // Head presentation to IF; empty queue shows a NOP at PC 0.
   always_comb begin
      fetch_valid = (count_reg != '0);
      fetch_insn  = NOP_INSN;
      fetch_pc    = 32'h0000_0000;
      if (fetch_valid) begin
         fetch_insn = insn_mem[rd_ptr_reg];
         fetch_pc   = pc_mem[rd_ptr_reg];
      end
   end

   assign mem_req  = mem_req_reg;
   assign mem_addr = mem_addr_reg;

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Bench for fetch_prefetch_buffer: directed scenarios followed by random
// ready/redirect/memory-latency traffic, checked against a queue-based
// reference model of the fetch stream.
module tb_fetch_prefetch_buffer;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        fetch_valid;
   logic [31:0] fetch_insn;
   logic [31:0] fetch_pc;
   logic        fetch_ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   fetch_prefetch_buffer #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC),
      .NOP_INSN (NOP_INSN)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .fetch_valid (fetch_valid),
      .fetch_insn  (fetch_insn),
      .fetch_pc    (fetch_pc),
      .fetch_ready (fetch_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
   } entry_t;

   // Reference model: queue of instructions IF should see, the address the
   // next accepted fetch must carry, and whether the outstanding request
   // belongs to a stream killed by a redirect.
   entry_t      mq[$];
   logic [31:0] exp_fetch;
   bit          stale;

   int n_checks = 0;
   int n_pass   = 0;
   int lat_min  = 0;
   int lat_max  = 0;
   int wait_left = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_req"},   {31'd0, mem_req},     32'd0);
      check_eq({tag, "_addr"},  mem_addr,             RESET_PC);
      check_eq({tag, "_valid"}, {31'd0, fetch_valid}, 32'd0);
      check_eq({tag, "_insn"},  fetch_insn,           NOP_INSN);
      check_eq({tag, "_pc"},    fetch_pc,             32'd0);
   endtask

   task automatic model_reset();
      mq.delete();
      exp_fetch = RESET_PC;
      stale     = 1'b0;
   endtask

   // Memory: acks each request after a random number of wait cycles.
   task automatic mem_respond();
      if (!rst_n || !mem_req) begin
         mem_ack = 1'b0;
      end else if (wait_left > 0) begin
         wait_left--;
         mem_ack = 1'b0;
      end else begin
         mem_ack   = 1'b1;
         mem_rdata = mem_word(mem_addr);
         wait_left = int'($urandom_range(lat_max, lat_min));
      end
   endtask

   // One clock: drive IF-side inputs, advance, update model, compare.
   task automatic cyc(input logic rdy, input logic rd, input logic [31:0] rpc);
      logic        p_req;
      logic        p_ack;
      logic [31:0] p_addr;
      logic [31:0] p_rdata;
      bit          acc;
      fetch_ready = rdy;
      redirect    = rd;
      redirect_pc = rpc;
      p_req   = mem_req;
      p_ack   = mem_ack;
      p_addr  = mem_addr;
      p_rdata = mem_rdata;
      @(posedge clk);
      #1;
      acc = p_req && p_ack && !stale && !rd;
      if (rd) begin
         mq.delete();
         exp_fetch = rpc & 32'hFFFF_FFFC;
      end else begin
         if (mq.size() > 0 && rdy) void'(mq.pop_front());
         if (acc) begin
            check_eq("push_addr", p_addr, exp_fetch);
            mq.push_back('{pc: p_addr, insn: p_rdata});
            exp_fetch = p_addr + 32'd4;
         end
      end
      if (p_req && p_ack) stale = 1'b0;
      if (rd && p_req && !p_ack) stale = 1'b1;

      check_eq("valid", {31'd0, fetch_valid}, (mq.size() != 0) ? 32'd1 : 32'd0);
      if (mq.size() != 0) begin
         check_eq("head_pc",   fetch_pc,   mq[0].pc);
         check_eq("head_insn", fetch_insn, mq[0].insn);
      end else begin
         check_eq("empty_pc",   fetch_pc,   32'd0);
         check_eq("empty_insn", fetch_insn, NOP_INSN);
      end
      check_eq("addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
      if (p_req && !p_ack) begin
         check_eq("req_hold",  {31'd0, mem_req}, 32'd1);
         check_eq("addr_hold", mem_addr, p_addr);
      end
      if (!mem_req) check_eq("idle_only_full", mq.size(), DEPTH);
      redirect = 1'b0;
      mem_respond();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit found;
      logic rdy;
      logic rd;
      logic [31:0] rpc;

      rst_n       = 1'b0;
      fetch_ready = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      mem_ack     = 1'b0;
      mem_rdata   = 32'd0;
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst_n = 1'b1;

      // First edge after release issues the reset-PC fetch.
      cyc(1'b0, 1'b0, 32'd0);
      check_eq("first_req",  {31'd0, mem_req}, 32'd1);
      check_eq("first_addr", mem_addr, RESET_PC);

      // Fill with IF stalled: four acks, then the request drops at 0x10.
      repeat (8) cyc(1'b0, 1'b0, 32'd0);
      check_eq("fill_req_drop", {31'd0, mem_req}, 32'd0);
      check_eq("fill_addr",     mem_addr, 32'h10);

      // Drain in order, fetch resumes at 0x10.
      for (int i = 0; i < DEPTH; i++) begin
         check_eq("drain_pc", fetch_pc, 32'(i * 4));
         cyc(1'b1, 1'b0, 32'd0);
      end
      repeat (10) cyc(1'b1, 1'b0, 32'd0);
      check_eq("stream_valid", {31'd0, fetch_valid}, 32'd1);

      // Redirect to 0x103 on an edge with both an ack and a pop.
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (mem_req && mem_ack && fetch_valid) found = 1'b1;
         else cyc(1'b1, 1'b0, 32'd0);
      end
      check_eq("find_ack_pop", {31'd0, found}, 32'd1);
      cyc(1'b1, 1'b1, 32'h103);
      check_eq("rd103_valid", {31'd0, fetch_valid}, 32'd0);
      check_eq("rd103_req",   {31'd0, mem_req}, 32'd1);
      check_eq("rd103_addr",  mem_addr, 32'h100);

      // PC wrap at the top of the address space.
      cyc(1'b1, 1'b1, 32'hFFFF_FFFC);
      check_eq("wrap_pre_addr", mem_addr, 32'hFFFF_FFFC);
      cyc(1'b1, 1'b0, 32'd0);
      check_eq("wrap_addr",     mem_addr, 32'h0000_0000);
      check_eq("wrap_head_pc",  fetch_pc, 32'hFFFF_FFFC);

      // Slow memory, then redirect to 0x200 while a request is waiting.
      lat_min = 3;
      lat_max = 3;
      repeat (20) cyc(1'b1, 1'b0, 32'd0);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (mem_req && !mem_ack && wait_left >= 1) found = 1'b1;
         else cyc(1'b1, 1'b0, 32'd0);
      end
      check_eq("find_wait", {31'd0, found}, 32'd1);
      cyc(1'b1, 1'b1, 32'h200);
      check_eq("rd200_valid", {31'd0, fetch_valid}, 32'd0);
      check_eq("rd200_flush_req", {31'd0, mem_req}, 32'd1);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (fetch_valid) found = 1'b1;
         else cyc(1'b0, 1'b0, 32'd0);
      end
      check_eq("rd200_arrives", {31'd0, found}, 32'd1);
      check_eq("rd200_first_pc", fetch_pc, 32'h200);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) begin
            lat_min = 0;
            lat_max = int'($urandom_range(3, 0));
         end
         rdy = ((i / 300) % 3 == 2) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
         rd  = ($urandom % 32 == 0);
         rpc = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
         cyc(rdy, rd, rpc);
      end

      // Asynchronous reset in the middle of a request; late ack ignored.
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (mem_req) found = 1'b1;
         else cyc(1'b1, 1'b0, 32'd0);
      end
      check_eq("find_req_for_reset", {31'd0, found}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_values("async_reset");
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset_late_ack");
      rst_n   = 1'b1;
      mem_ack = 1'b0;
      model_reset();
      lat_min = 0;
      lat_max = 2;
      cyc(1'b1, 1'b0, 32'd0);
      check_eq("rerun_req",  {31'd0, mem_req}, 32'd1);
      check_eq("rerun_addr", mem_addr, RESET_PC);
      repeat (200) cyc($urandom % 2 == 0, $urandom % 40 == 0, $urandom);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
